// File: rtl/r2sdf_bitrev_reorder.sv
// r2sdf_bitrev_reorder: ping-pong reorder buffer turning bit-reversed R2SDF
// output frames into natural-order frames with sync/valid.
// Optional feature macro: R2SDF_REORDER_ERR_EN adds the 'err' resync pulse.

package R2SdfDefinesPkg;
  localparam int DW = 16;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } Cplx;
endpackage

module r2sdf_bitrev_reorder
  import R2SdfDefinesPkg::*;
#(
  parameter int STG = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  Cplx  in,
  input  logic in_sync,
  output Cplx  out,
  output logic out_valid,
  output logic out_sync
`ifdef R2SDF_REORDER_ERR_EN
  ,
  output logic err
`endif
);

  localparam int N = 2 ** STG;

  typedef enum logic { W_IDLE, W_FILL } wstate_e;
  typedef enum logic { R_IDLE, R_RUN } rstate_e;

  function automatic logic [STG-1:0] bitrev(input logic [STG-1:0] a);
    logic [STG-1:0] r;
    for (int i = 0; i < STG; i++) r[i] = a[STG-1-i];
    return r;
  endfunction

  // Two banks of N words; the bank bit is the address MSB.
  Cplx mem_q [2*N];

  wstate_e        wstate_q, wstate_d;
  rstate_e        rstate_q, rstate_d;
  logic [STG-1:0] wcnt_q, wcnt_d;
  logic [STG-1:0] rcnt_q, rcnt_d;
  logic           wbank_q, wbank_d;
  logic           rbank_q, rbank_d;
  Cplx            out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic           out_sync_q, out_sync_d;

  logic           we;
  logic [STG:0]   waddr;
  logic [STG:0]   raddr;
  logic           done;
  logic           rd_issue;
`ifdef R2SDF_REORDER_ERR_EN
  logic           resync;
  logic           err_q, err_d;
`endif

  // Write side: scatter each sample to its bit-reversed slot; detect frame end and resync.
  always_comb begin
    wstate_d = wstate_q;
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    we       = 1'b0;
    waddr    = {wbank_q, bitrev(wcnt_q)};
    done     = 1'b0;
`ifdef R2SDF_REORDER_ERR_EN
    resync   = 1'b0;
`endif
    case (wstate_q)
      W_IDLE: begin
        if (in_sync) begin
          we       = 1'b1;
          waddr    = {wbank_q, {STG{1'b0}}};
          wcnt_d   = STG'(1);
          wstate_d = W_FILL;
        end
      end
      W_FILL: begin
        we = 1'b1;
        if (in_sync && (wcnt_q != '0)) begin
          // Drop the partial frame and restart in the same bank.
          waddr  = {wbank_q, {STG{1'b0}}};
          wcnt_d = STG'(1);
`ifdef R2SDF_REORDER_ERR_EN
          resync = 1'b1;
`endif
        end else begin
          // Counter wraps to 0 after the last word, so streaming needs no sync.
          wcnt_d = wcnt_q + STG'(1);
          if (wcnt_q == STG'(N-1)) begin
            done    = 1'b1;
            wbank_d = ~wbank_q;
          end
        end
      end
      default: ;
    endcase
  end

  // Read side: sweep the completed bank in natural order; a new completion restarts without a bubble.
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    rbank_d  = rbank_q;
    rd_issue = 1'b0;
    raddr    = {rbank_q, rcnt_q};
    if (rstate_q == R_RUN) begin
      rd_issue = 1'b1;
      rcnt_d   = rcnt_q + STG'(1);
      if (rcnt_q == STG'(N-1)) rstate_d = R_IDLE;
    end
    if (done) begin
      rstate_d = R_RUN;
      rcnt_d   = '0;
      rbank_d  = wbank_q;
    end
  end

  // Output register doubles as the RAM read register; data holds when no read is issued.
  always_comb begin
    out_d       = rd_issue ? mem_q[raddr] : out_q;
    out_valid_d = rd_issue;
    out_sync_d  = rd_issue && (rcnt_q == '0);
`ifdef R2SDF_REORDER_ERR_EN
    err_d       = resync;
`endif
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (rst_n && en && we) mem_q[waddr] <= in;
  end

  // State and output registers; reset dominates, en freezes everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate_q    <= W_IDLE;
      rstate_q    <= R_IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
`ifdef R2SDF_REORDER_ERR_EN
      err_q       <= 1'b0;
`endif
    end else if (en) begin
      wstate_q    <= wstate_d;
      rstate_q    <= rstate_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sync_q  <= out_sync_d;
`ifdef R2SDF_REORDER_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_sync  = out_sync_q;
`ifdef R2SDF_REORDER_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_r2sdf_bitrev_reorder.sv
// Bench for r2sdf_bitrev_reorder (STG=4): directed steps, scoreboard of
// expected natural-order outputs keyed by enabled-cycle index.
module tb_r2sdf_bitrev_reorder;
  import R2SdfDefinesPkg::*;

  localparam int N = 16;

  logic clk;
  logic rst_n;
  logic en;
  Cplx  din;
  logic in_sync;
  Cplx  dout;
  logic out_valid;
  logic out_sync;
`ifdef R2SDF_REORDER_ERR_EN
  logic err;
`endif

  r2sdf_bitrev_reorder #(.STG(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in       (din),
    .in_sync  (in_sync),
    .out      (dout),
    .out_valid(out_valid),
    .out_sync (out_sync)
`ifdef R2SDF_REORDER_ERR_EN
    ,
    .err      (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    Cplx  d;
    logic s;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ecnt   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] br4(input int k);
    logic [3:0] v;
    v = 4'(k);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Input sample k of a frame carries natural index br4(k).
  function automatic Cplx mk(input int base, input int k);
    Cplx c;
    int  v;
    v = base + int'(br4(k));
    c.re = DW'(v);
    c.im = DW'(-v);
    return c;
  endfunction

  function automatic Cplx nat(input int base, input int n);
    Cplx c;
    c.re = DW'(base + n);
    c.im = DW'(-(base + n));
    return c;
  endfunction

  // Enabled, non-reset edges seen so far.
  always @(posedge clk) if (rst_n && en) ecnt <= ecnt + 1;

  // Output monitor: pops at the exact enabled cycle each sample is due, checks holds while en=0.
  logic              prev_rst = 1'b0;
  logic              prev_en  = 1'b1;
  logic [2*DW+1:0]   prev_snap;
  exp_t              mon_e;
  always @(negedge clk) begin
    if (prev_rst && !prev_en) chk("hold", {dout, out_valid, out_sync}, prev_snap);
    if (rst_n && en) begin
      if (sb.size() != 0 && sb[0].cyc <= ecnt) begin
        mon_e = sb.pop_front();
        chk("out_valid", out_valid, 1'b1);
        chk("out_sync", out_sync, mon_e.s);
        chk("out_data", dout, mon_e.d);
      end else begin
        chk("idle_valid", out_valid, 1'b0);
        chk("idle_sync", out_sync, 1'b0);
      end
    end
    prev_rst  = rst_n;
    prev_en   = en;
    prev_snap = {dout, out_valid, out_sync};
  end

  task automatic step(input logic e, input Cplx d, input logic s);
    en      = e;
    din     = d;
    in_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input int base, input int c0);
    exp_t x;
    for (int n = 0; n < N; n++) begin
      x.d   = nat(base, n);
      x.s   = (n == 0);
      x.cyc = c0 + N + 1 + n;
      sb.push_back(x);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, Cplx'($urandom), 1'($urandom));
      chk("rst_out", dout, '0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_sync", out_sync, 1'b0);
`ifdef R2SDF_REORDER_ERR_EN
      chk("rst_err", err, 1'b0);
`endif
    end
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, Cplx'($urandom), 1'b0);
  endtask

  // Sync held high keeps restarting the write side, so no further frame ever completes.
  task automatic filler(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) step(1'b0, Cplx'($urandom), 1'($urandom));
      step(1'b1, Cplx'($urandom), 1'b1);
    end
  endtask

  task automatic send_frame(input int base, input bit sync0, input bit gaps);
    for (int k = 0; k < N; k++) begin
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++)
          step(1'b0, Cplx'($urandom), 1'($urandom));
      if (k == 0) expect_frame(base, ecnt);
      step(1'b1, mk(base, k), sync0 && (k == 0));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    din     = '0;
    in_sync = 1'b0;

    // Reset values, then unsynced input must be ignored.
    do_reset();
    idle(5);

    // Single frame; nothing valid after its 16 outputs.
    send_frame(0, 1'b1, 1'b0);
    filler(24, 1'b0);
    chk("single_drained", sb.size(), 0);

    // Four back-to-back frames, sync only on the first.
    do_reset();
    idle(2);
    send_frame(100, 1'b1, 1'b0);
    send_frame(200, 1'b0, 1'b0);
    send_frame(300, 1'b0, 1'b0);
    send_frame(400, 1'b0, 1'b0);
    filler(24, 1'b0);
    chk("stream_drained", sb.size(), 0);

    // Single frame with random enable gaps.
    do_reset();
    idle(2);
    send_frame(1000, 1'b1, 1'b1);
    filler(30, 1'b1);
    en = 1'b1;
    filler(4, 1'b0);
    chk("gaps_drained", sb.size(), 0);

    // Mid-frame resync: 7-sample partial frame is dropped, frame restarted at t0+7.
    do_reset();
    idle(2);
    for (int k = 0; k < 7; k++) begin
      step(1'b1, mk(500, k), k == 0);
`ifdef R2SDF_REORDER_ERR_EN
      chk("err_a", err, 1'b0);
`endif
    end
    for (int k = 0; k < N; k++) begin
      if (k == 0) expect_frame(600, ecnt);
      step(1'b1, mk(600, k), k == 0);
`ifdef R2SDF_REORDER_ERR_EN
      chk("err_b", err, k == 0);
`endif
    end
    filler(24, 1'b0);
    chk("resync_drained", sb.size(), 0);

    // Second frame's sync lands right after the first completes: no output gap.
    do_reset();
    idle(3);
    send_frame(2000, 1'b1, 1'b0);
    send_frame(3000, 1'b1, 1'b0);
    filler(24, 1'b0);
    chk("b2b_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/r2sdf_bitrev_reorder.md
# r2sdf_bitrev_reorder

Streaming output reorder buffer for the radix-2 SDF FFT core. The block sits directly downstream of the R2SDF pipeline and takes its bit-reversed-order complex output frames. It writes each frame into one half of a ping-pong RAM at bit-reversed addresses, then reads that half back in natural order while the next frame fills the other half. It emits natural-order frames with a frame sync and a valid flag.

## Interface
- `STG`, default 4: FFT stages; frame length N = 2**STG.
- `DW`, from `R2SdfDefinesPkg`: component width of `Cplx`. This is not a module parameter.
- `clk`  in  1  rising-edge clock; the block has a single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  clock enable; all state advances only when `en`=1.
- `in`  in  `Cplx` (2×DW)  FFT output sample, in bit-reversed order.
- `in_sync`  in  1  marks input sample index 0 of a frame; coincident with that sample.
- `out`  out  `Cplx`  natural-order sample, registered.
- `out_valid`  out  1  `out` carries a valid sample, registered.
- `out_sync`  out  1  marks output sample index 0 of a frame, registered.
- `err`  out  1  present only with `R2SDF_REORDER_ERR_EN`; see Configuration.

## Operation
- **Storage.** 2×N words of 2·DW bits, split into bank 0 and bank 1. Read port latency is 1 cycle.
- **Write FSM**, states W_IDLE and W_FILL. Reset state is W_IDLE.
  - W_IDLE: samples are ignored. `in_sync`=1 → write `in` to addr bitrev(0)=0 of bank `wbank`, set `wcnt`=1, go to W_FILL.
  - W_FILL, each `en` cycle: write `in` to bank `wbank` at addr bitrev_STG(`wcnt`), then `wcnt`++.
  - When `wcnt`=N−1 is written: the frame is complete. Toggle `wbank`, then start a read of the completed bank.
  - Because of the toggle, the next sample, if `in_sync`, goes into the other bank.
  - After completion the FSM stays in W_FILL with `wcnt` wrapped to 0. The next sample is accepted as index 0 whether or not `in_sync` is high. This makes continuous streaming work without a sync on every frame.
  - `in_sync`=1 while in W_FILL with `wcnt`≠0 (mid-frame resync): discard the partial frame. `wbank` is unchanged. Write `in` as index 0 and set `wcnt`=1. No read is started for the discarded frame.
- **Read FSM**, states R_IDLE and R_RUN.
  - Frame completion → R_RUN with `rbank` = completed bank and `rcnt`=0.
  - In R_RUN, each `en` cycle: issue read at `rcnt`, then `rcnt`++. After `rcnt`=N−1 → R_IDLE.
  - If a completion coincides with the final read cycle, go straight back to R_RUN with `rcnt`=0 on the new bank. There is no bubble.
- **Outputs.** These are registered one cycle after the read address is issued.
  - `out_valid` = read issued.
  - `out_sync` = read issued with `rcnt`=0.
  - `out` = RAM data. When `out_valid`=0, `out` holds its last value.
- **No overlap.** A frame takes N write cycles, so a read never overlaps a write to the same bank.
- **No arithmetic.** Data passes bit-exact with no width change.

## Timing
- **Reset values:** `out`={0,0}, `out_valid`=0, `out_sync`=0, `err`=0. Both FSMs idle, `wcnt`=`rcnt`=0, `wbank`=0.
- **Latency:** input index 0 at enabled cycle t0 → output index 0 (`out_sync`=1) at enabled cycle t0+N+1. Samples follow on consecutive enabled cycles.
- **Clock enable:** `en`=0 freezes all state and outputs. `out_valid` and `out_sync` hold their values, so the consumer must qualify them with `en`.
- **Throughput:** 1 sample per enabled cycle, continuously. Output is gapless when input is gapless.
- **Reset mid-operation:** takes effect at the next edge. Both frames are dropped, and the block waits for `in_sync`.

## Configuration
- **`R2SDF_REORDER_ERR_EN` defined:** adds the `err` output.
  - `err` is a 1-cycle registered pulse on each mid-frame resync (`in_sync`=1 in W_FILL with `wcnt`≠0).
  - `err` is 0 out of reset.
- **Not defined:** there is no `err` port and no detection logic. Resync behaviour is identical.

## Test plan
All tests use STG=4 (N=16).
- **Reset.** Hold `rst_n`=0 for 3 cycles with random `in` and `in_sync` → `out`={0,0}, `out_valid`=0, `out_sync`=0. After release, `out_valid` stays 0 until 17 cycles after the first `in_sync`.
- **Single frame.** Assert `in_sync` at t0. Drive sample k with re=bitrev4(k), im=−bitrev4(k) → `out_sync`=1 at t0+17, then `out`.re=0,1,…,15 and im=0,−1,…,−15 on consecutive cycles. `out_valid`=0 from t0+33.
- **Streaming.** Send 4 back-to-back frames with `in_sync` only on the first → 64 consecutive valid outputs. `out_sync` at t0+17, +33, +49 and +65. Each frame's data is correct.
- **Enable gaps.** Repeat the single-frame test with `en` toggled pseudo-randomly at 50% → output data and order are identical when counted in enabled cycles. Outputs are held while `en`=0.
- **Mid-frame resync.** Assert `in_sync` at t0, then again at t0+7 → the first partial frame is never output. `out_sync` occurs at t0+24. With `R2SDF_REORDER_ERR_EN`, `err`=1 for exactly one cycle at t0+8.
- **Back-to-back boundary.** Frame 2's `in_sync` arrives on the cycle right after frame 1 completes → no gap between frame 1 output sample 15 and frame 2 output sample 0.
